// File: rtl/cdc_src_flush_fifo.sv
// -----------------------------------------------------------------------------
// cdc_src_flush_fifo
//
// Source-side buffer placed in front of a clearable clock-domain crossing.
// Items from upstream are held in a small FIFO and forwarded to the CDC source
// port. While the CDC reports a pending clear, both handshakes are blocked, the
// FIFO is emptied, and the number of discarded items is accumulated. After the
// clear drops, one recovery cycle passes before normal operation resumes.
//
// Optional feature:
//   CDC_SRC_FIFO_DROP_CNT_EN - when defined, dropped_cnt_o is a saturating
//   16-bit count of items discarded by flushes. When undefined, dropped_cnt_o
//   is tied to zero and no counter flops exist.
//
// Ports:
//   src_clk_i        source-domain clock, all state updates on rising edge
//   src_rst_ni       asynchronous active-low reset
//   clear_pending_i  clear-pending flag from the downstream clearable CDC
//   in_data_i        upstream payload
//   in_valid_i       upstream valid
//   in_ready_o       upstream ready
//   cdc_data_o       payload to the CDC source side (entry at read pointer)
//   cdc_valid_o      valid to the CDC
//   cdc_ready_i      ready from the CDC
//   usage_o          number of stored items, 0..DEPTH
//   flush_busy_o     high while flushing or recovering
//   dropped_cnt_o    saturating count of items discarded by flushes
// -----------------------------------------------------------------------------
module cdc_src_flush_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    src_clk_i,
    input  logic                    src_rst_ni,
    input  logic                    clear_pending_i,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    output logic [DATA_WIDTH-1:0]   cdc_data_o,
    output logic                    cdc_valid_o,
    input  logic                    cdc_ready_i,
    output logic [$clog2(DEPTH):0]  usage_o,
    output logic                    flush_busy_o,
    output logic [15:0]             dropped_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        usage_q, usage_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic push_s;
    logic pop_s;
    logic run_s;

    // Handshakes are gated combinationally by the clear flag so no transfer
    // can slip through on the very edge that starts a flush.
    assign run_s        = (state_q == ST_RUN) && !clear_pending_i;
    assign in_ready_o   = run_s && (usage_q < CNT_FULL);
    assign cdc_valid_o  = run_s && (usage_q != {CNT_W{1'b0}});
    assign push_s       = in_valid_i && in_ready_o;
    assign pop_s        = cdc_valid_o && cdc_ready_i;
    assign cdc_data_o   = mem_q[rd_ptr_q];
    assign usage_o      = usage_q;
    assign flush_busy_o = (state_q != ST_RUN);

    // Next-state logic for the flush FSM, pointers and occupancy.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usage_d  = usage_q;
        case (state_q)
            ST_RUN: begin
                if (clear_pending_i) begin
                    state_d  = ST_FLUSH;
                    wr_ptr_d = {PTR_W{1'b0}};
                    rd_ptr_d = {PTR_W{1'b0}};
                    usage_d  = {CNT_W{1'b0}};
                end else begin
                    // DEPTH is a power of two, so pointer increments wrap naturally.
                    if (push_s) begin
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end else begin
                        wr_ptr_d = wr_ptr_q;
                    end
                    if (pop_s) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q;
                    end
                    case ({push_s, pop_s})
                        2'b10:   usage_d = usage_q + CNT_ONE;
                        2'b01:   usage_d = usage_q - CNT_ONE;
                        default: usage_d = usage_q;
                    endcase
                end
            end
            ST_FLUSH: begin
                if (clear_pending_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                // FIFO is already empty here, so re-entering FLUSH drops nothing.
                if (clear_pending_i) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                wr_ptr_d = {PTR_W{1'b0}};
                rd_ptr_d = {PTR_W{1'b0}};
                usage_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            usage_q  <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usage_q  <= usage_d;
        end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge src_clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

`ifdef CDC_SRC_FIFO_DROP_CNT_EN
    logic [15:0] dropped_cnt_q, dropped_cnt_d;

    // Saturating 16-bit add of the current occupancy.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNT_W-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        if (sum[16]) begin
            return 16'hFFFF;
        end else begin
            return sum[15:0];
        end
    endfunction

    // Accumulate the occupancy discarded when a flush starts from RUN.
    always_comb begin
        dropped_cnt_d = dropped_cnt_q;
        if ((state_q == ST_RUN) && clear_pending_i) begin
            dropped_cnt_d = sat_add16(dropped_cnt_q, usage_q);
        end else begin
            dropped_cnt_d = dropped_cnt_q;
        end
    end

    // Dropped-item counter register.
    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            dropped_cnt_q <= 16'h0000;
        end else begin
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    assign dropped_cnt_o = dropped_cnt_q;
`else
    assign dropped_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_cdc_src_flush_fifo.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cdc_src_flush_fifo (DEPTH=4, DATA_WIDTH=32).
// A queue-based reference model follows the documented behaviour: an item
// list, a RUN/FLUSH/RECOVER mode and a saturating drop tally. Inputs change
// on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_cdc_src_flush_fifo;

    localparam int W = 32;
    localparam int D = 4;
    localparam int M_RUN = 0, M_FLUSH = 1, M_RECOVER = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  cdc_data;
    logic          cdc_valid;
    logic          cdc_ready = 1'b0;
    logic [2:0]    usage;
    logic          busy;
    logic [15:0]   dropped;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [W-1:0] mq[$];
    int           m_mode = M_RUN;
    int unsigned  m_drop = 0;

    cdc_src_flush_fifo #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .src_clk_i       (clk),
        .src_rst_ni      (rst_n),
        .clear_pending_i (clr),
        .in_data_i       (in_data),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .cdc_data_o      (cdc_data),
        .cdc_valid_o     (cdc_valid),
        .cdc_ready_i     (cdc_ready),
        .usage_o         (usage),
        .flush_busy_o    (busy),
        .dropped_cnt_o   (dropped)
    );

    always #5 clk = ~clk;

    function automatic logic m_rdy();
        return (m_mode == M_RUN) && !clr && (mq.size() < D);
    endfunction

    function automatic logic m_vld();
        return (m_mode == M_RUN) && !clr && (mq.size() > 0);
    endfunction

    function automatic logic [15:0] m_dropped();
`ifdef CDC_SRC_FIFO_DROP_CNT_EN
        return 16'(m_drop);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_mode = M_RUN;
        m_drop = 0;
    endtask

    // Advance one clock: update the model from the inputs present at the edge.
    task automatic tick();
        logic do_push, do_pop;
        do_push = in_valid && m_rdy();
        do_pop  = m_vld() && cdc_ready;
        @(posedge clk);
        if (m_mode == M_RUN && clr) begin
            m_drop = (m_drop + mq.size() > 65535) ? 65535 : m_drop + mq.size();
            mq.delete();
            m_mode = M_FLUSH;
        end else if (m_mode == M_FLUSH) begin
            m_mode = clr ? M_FLUSH : M_RECOVER;
        end else if (m_mode == M_RECOVER) begin
            m_mode = clr ? M_FLUSH : M_RUN;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        cdc_ready = 1'b1;
        clr = 1'b0;
        repeat (D + 3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (cdc_valid !== 1'b0) begin bad++; $display("FAIL reset_cdc_valid got=%b exp=0", cdc_valid); end
        total++; if (usage !== 3'd0) begin bad++; $display("FAIL reset_usage got=%0d exp=0", usage); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (dropped !== 16'h0000) begin bad++; $display("FAIL reset_dropped got=%h exp=0", dropped); end
        clr = 1'b1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_clr_in_ready got=%b exp=0", in_ready); end
        clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        cdc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'hA000_0000 + 32'(i); #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready[%0d] got=%b exp=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0; #1;
        total++; if (usage !== 3'd4) begin bad++; $display("FAIL fill_usage got=%0d exp=4", usage); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
        // Full with a pop in the same cycle: the push must still be refused.
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; cdc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (in_ready !== (i == 0 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL fill_pop_ready[%0d] got=%b", i, in_ready); end
            total++; if (cdc_valid !== 1'b1 || cdc_data !== 32'hA000_0000 + 32'(i))
                begin bad++; $display("FAIL fill_order[%0d] got=%b/%h exp=1/%h", i, cdc_valid, cdc_data, 32'hA000_0000 + 32'(i)); end
            tick();
            in_valid = 1'b0;
        end
        #1;
        total++; if (usage !== 3'd0 || cdc_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%0d/%b exp=0/0", usage, cdc_valid); end
    endtask

    task automatic test_streaming();
        int pushed = 0, popped = 0;
        cdc_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (pushed < 10); in_data = 32'hB000_0000 + 32'(pushed); #1;
            total++; if (usage > 3'd1) begin bad++; $display("FAIL stream_usage[%0d] got=%0d exp<=1", c, usage); end
            if (c >= 1 && c <= 10) begin
                total++; if (cdc_valid !== 1'b1) begin bad++; $display("FAIL stream_rate[%0d] got=%b exp=1", c, cdc_valid); end
            end
            if (cdc_valid === 1'b1) begin
                total++; if (cdc_data !== 32'hB000_0000 + 32'(popped)) begin bad++; $display("FAIL stream_data got=%h exp=%h", cdc_data, 32'hB000_0000 + 32'(popped)); end
                popped++;
            end
            if (in_valid && in_ready === 1'b1) pushed++;
            tick();
        end
        total++; if (popped != 10 || pushed != 10) begin bad++; $display("FAIL stream_count got=%0d/%0d exp=10/10", pushed, popped); end
    endtask

    task automatic test_flush();
        int busy_cycles = 0;
        logic [15:0] drop_exp;
`ifdef CDC_SRC_FIFO_DROP_CNT_EN
        drop_exp = 16'd3;
`else
        drop_exp = 16'd0;
`endif
        cdc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'hC000_0000 + 32'(i); tick();
        end
        in_valid = 1'b1; cdc_ready = 1'b1; in_data = 32'h5555_0000;
        for (int c = 0; c < 8; c++) begin
            clr = (c < 4); #1;
            if (c >= 1 && c <= 5) begin
                total++; if (in_ready !== 1'b0 || cdc_valid !== 1'b0) begin bad++; $display("FAIL flush_handshake[%0d] got=%b/%b exp=0/0", c, in_ready, cdc_valid); end
                total++; if (usage !== 3'd0) begin bad++; $display("FAIL flush_usage[%0d] got=%0d exp=0", c, usage); end
                total++; if (dropped !== drop_exp) begin bad++; $display("FAIL flush_dropped[%0d] got=%0d exp=%0d", c, dropped, drop_exp); end
            end
            if (busy === 1'b1) busy_cycles++;
            tick();
        end
        total++; if (busy_cycles != 5) begin bad++; $display("FAIL flush_busy_len got=%0d exp=5", busy_cycles); end
        drain();
    endtask

    task automatic test_wrap();
        int sent = 0, got = 0, cyc = 0;
        while (got < 9 && cyc < 200) begin
            in_valid = (sent < 9); in_data = 32'hD000_0000 + 32'(sent); cdc_ready = (cyc % 2 == 1); #1;
            if (cdc_valid === 1'b1 && cdc_ready) begin
                total++; if (cdc_data !== 32'hD000_0000 + 32'(got)) begin bad++; $display("FAIL wrap_data got=%h exp=%h", cdc_data, 32'hD000_0000 + 32'(got)); end
                got++;
            end
            if (in_valid && in_ready === 1'b1) sent++;
            tick();
            cyc++;
        end
        total++; if (got != 9) begin bad++; $display("FAIL wrap_count got=%0d exp=9", got); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (clr) clr = ($urandom_range(0, 3) != 0);
            else     clr = ($urandom_range(0, 19) == 0);
            in_valid = 1'($urandom_range(0, 1));
            in_data = $urandom;
            cdc_ready = ($urandom_range(0, 2) != 0);
            #1;
            total++; if (in_ready !== m_rdy()) begin bad++; $display("FAIL rand_in_ready[%0d] got=%b exp=%b", c, in_ready, m_rdy()); end
            total++; if (cdc_valid !== m_vld()) begin bad++; $display("FAIL rand_cdc_valid[%0d] got=%b exp=%b", c, cdc_valid, m_vld()); end
            total++; if (usage !== 3'(mq.size())) begin bad++; $display("FAIL rand_usage[%0d] got=%0d exp=%0d", c, usage, mq.size()); end
            total++; if (busy !== (m_mode != M_RUN)) begin bad++; $display("FAIL rand_busy[%0d] got=%b exp=%b", c, busy, m_mode != M_RUN); end
            total++; if (dropped !== m_dropped()) begin bad++; $display("FAIL rand_dropped[%0d] got=%0d exp=%0d", c, dropped, m_dropped()); end
            if (m_vld()) begin
                total++; if (cdc_data !== mq[0]) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", c, cdc_data, mq[0]); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_saturation();
        logic [15:0] exp_final;
`ifdef CDC_SRC_FIFO_DROP_CNT_EN
        force dut.dropped_cnt_q = 16'hFFFE;
        #1;
        release dut.dropped_cnt_q;
        m_drop = 32'hFFFE;
        #1;
        total++; if (dropped !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", dropped); end
        exp_final = 16'hFFFF;
`else
        exp_final = 16'h0000;
`endif
        cdc_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = $urandom; tick();
        end
        in_valid = 1'b0; #1;
        total++; if (usage !== 3'd4) begin bad++; $display("FAIL sat_fill got=%0d exp=4", usage); end
        for (int c = 0; c < 6; c++) begin
            clr = (c < 2); #1;
            if (c >= 1) begin
                total++; if (dropped !== exp_final) begin bad++; $display("FAIL sat_dropped[%0d] got=%h exp=%h", c, dropped, exp_final); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_reset_mid();
        cdc_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'hE000_0000 + 32'(i); tick();
        end
        in_valid = 1'b0; #1;
        total++; if (usage !== 3'd2) begin bad++; $display("FAIL rstmid_pre got=%0d exp=2", usage); end
        rst_n = 1'b0; #1;
        model_reset();
        total++; if (usage !== 3'd0) begin bad++; $display("FAIL rstmid_usage got=%0d exp=0", usage); end
        total++; if (cdc_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b exp=0", cdc_valid); end
        total++; if (dropped !== 16'h0000) begin bad++; $display("FAIL rstmid_dropped got=%h exp=0", dropped); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 32'h1234_5678; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0; #1;
        total++; if (cdc_valid !== 1'b1 || cdc_data !== 32'h1234_5678) begin bad++; $display("FAIL rstmid_first got=%b/%h exp=1/12345678", cdc_valid, cdc_data); end
        total++; if (dropped !== 16'h0000) begin bad++; $display("FAIL rstmid_nocount got=%h exp=0", dropped); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_streaming();
        test_flush();
        test_wrap();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
